// File: rtl/snitch_pkg.sv
// Shared types for the Snitch FPU issue controller.
// Holds the default widths, the issue FSM state encoding and the request
// payload carried by the registered output stage.
package snitch_pkg;

    localparam int unsigned FpuAddrWidth = 5;
    localparam int unsigned FpuDepth     = 4;
    localparam int unsigned FpuNumSrc    = 3;
    localparam int unsigned FpuOpWidth   = 8;

    typedef enum logic {
        FpuIssueRun   = 1'b0,
        FpuIssueDrain = 1'b1
    } fpu_issue_state_e;

    typedef struct packed {
        logic [FpuOpWidth-1:0]   op;
        logic [FpuAddrWidth-1:0] rd;
        logic [FpuDepth-1:0]     tag;
    } fpu_issue_req_t;

endpackage

// File: rtl/snitch_fpu_hazard_chk.sv
// Combinational RAW/WAW/full hazard reduction over the scoreboard test flags.
// Ports:
//   rs_used   - per-source read enables
//   rd_used   - instruction writes rd
//   present   - scoreboard hits, [NumSrc-1:0] sources, [NumSrc] destination
//   full      - no free scoreboard entry
//   hazard_c  - instruction must stall
module snitch_fpu_hazard_chk #(
    parameter int unsigned NumSrc = 3
) (
    input  logic [NumSrc-1:0] rs_used,
    input  logic              rd_used,
    input  logic [NumSrc:0]   present,
    input  logic              full,
    output logic              hazard_c
);

    // A full scoreboard only matters when we need a new entry.
    assign hazard_c = (|(rs_used & present[NumSrc-1:0]))
                    | (rd_used & present[NumSrc])
                    | (rd_used & full);

endmodule

// File: rtl/snitch_fpu_issue_ctrl.sv
// FPU issue controller: stalls the FP sequencer on scoreboard hazards, pushes
// rd into the scoreboard on issue, pops on writeback, registers the FPU
// request in one output stage and drains all outstanding ops on a fence.
// Optional stall perf counter: define SNITCH_FPU_ISSUE_PERF_EN.
// Ports:
//   clk_i / rst_i            clock, synchronous active-high reset
//   in_*                     sequencer instruction handshake and payload
//   out_*                    registered FPU request (valid/ready, op, rd, tag)
//   wb_valid_i / wb_tag_i    FPU writeback, always accepted
//   sb_*                     scoreboard push/pop/test interface
//   outstanding_o            ops pushed but not yet popped
//   stall_cycles_o           cycles with in_valid_i & ~in_ready_o (perf build)
module snitch_fpu_issue_ctrl
    import snitch_pkg::*;
#(
    parameter int unsigned AddrWidth = FpuAddrWidth,
    parameter int unsigned Depth     = FpuDepth,
    parameter int unsigned NumSrc    = FpuNumSrc,
    parameter int unsigned OpWidth   = FpuOpWidth,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [OpWidth-1:0]            in_op_i,
    input  logic [NumSrc*AddrWidth-1:0]   in_rs_i,
    input  logic [NumSrc-1:0]             in_rs_used_i,
    input  logic [AddrWidth-1:0]          in_rd_i,
    input  logic                          in_rd_used_i,
    input  logic                          in_fence_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [OpWidth-1:0]            out_op_o,
    output logic [AddrWidth-1:0]          out_rd_o,
    output logic [Depth-1:0]              out_tag_o,
    input  logic                          wb_valid_i,
    input  logic [Depth-1:0]              wb_tag_i,
    output logic                          sb_push_valid_o,
    output logic [AddrWidth-1:0]          sb_push_rd_addr_o,
    input  logic [Depth-1:0]              sb_entry_index_i,
    output logic                          sb_pop_valid_o,
    output logic [Depth-1:0]              sb_pop_index_o,
    output logic [(NumSrc+1)*AddrWidth-1:0] sb_test_addr_o,
    input  logic [NumSrc:0]               sb_test_present_i,
    input  logic                          sb_full_i,
    output logic [CntWidth-1:0]           outstanding_o,
    output logic [31:0]                   stall_cycles_o
);

    fpu_issue_state_e      state_q, state_d;
    fpu_issue_req_t        req_q, req_d;
    logic                  out_valid_q;
    logic [CntWidth-1:0]   outstanding_q;
    logic                  hazard_c;
    logic                  slot_free_c;
    logic                  drained_c;
    logic                  accept_c;
    logic                  push_c;
    logic                  pop_c;

    // Scoreboard test/pop wiring: test vector is {rd, rs[NumSrc-1:0]}.
    assign sb_test_addr_o    = {in_rd_i, in_rs_i};
    assign sb_push_rd_addr_o = in_rd_i;
    assign sb_pop_valid_o    = wb_valid_i;
    assign sb_pop_index_o    = wb_tag_i;

    snitch_fpu_hazard_chk #(
        .NumSrc (NumSrc)
    ) i_hazard_chk (
        .rs_used  (in_rs_used_i),
        .rd_used  (in_rd_used_i),
        .present  (sb_test_present_i),
        .full     (sb_full_i),
        .hazard_c (hazard_c)
    );

    assign slot_free_c = ~out_valid_q | out_ready_i;
    // Uses the registered count, so a writeback in this cycle is seen next cycle.
    assign drained_c   = (outstanding_q == '0) & ~out_valid_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FpuIssueRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FpuIssueRun: begin
                if (in_valid_i && in_fence_i) begin
                    state_d = FpuIssueDrain;
                end
            end
            FpuIssueDrain: begin
                if (drained_c) begin
                    state_d = FpuIssueRun;
                end
            end
            default: state_d = FpuIssueRun;
        endcase
    end

    // FSM outputs: in DRAIN the ready pulse consumes the fence without forwarding.
    always_comb begin
        in_ready_o = 1'b0;
        case (state_q)
            FpuIssueRun:   in_ready_o = ~in_fence_i & ~hazard_c & slot_free_c;
            FpuIssueDrain: in_ready_o = drained_c;
            default:       in_ready_o = 1'b0;
        endcase
    end

    assign accept_c = in_valid_i & in_ready_o & (state_q == FpuIssueRun);
    assign push_c   = accept_c & in_rd_used_i;
    assign pop_c    = wb_valid_i;
    assign sb_push_valid_o = push_c;

    // Output stage payload; ops without rd carry tag 0.
    always_comb begin
        req_d     = '0;
        req_d.op  = in_op_i;
        req_d.rd  = in_rd_i;
        req_d.tag = in_rd_used_i ? sb_entry_index_i : '0;
    end

    // Output stage: payload only loads on accept, so it is stable under backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            req_q       <= '0;
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            req_q       <= req_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_op_o    = req_q.op;
    assign out_rd_o    = req_q.rd;
    assign out_tag_o   = req_q.tag;

    // Outstanding-op counter; a pop at zero is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            case ({push_c, pop_c})
                2'b10:   outstanding_q <= outstanding_q + CntWidth'(1);
                2'b01: begin
                    if (outstanding_q != '0) begin
                        outstanding_q <= outstanding_q - CntWidth'(1);
                    end
                end
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign outstanding_o = outstanding_q;

    // Writeback with nothing outstanding means the FPU and scoreboard disagree.
    pop_underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop_c && (outstanding_q == '0)));

`ifdef SNITCH_FPU_ISSUE_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of sequencer stall cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (in_valid_i && !in_ready_o && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule
